// File: rtl/context_pixel_dec.sv
// LOCO-I decoder causal-context generator: presents a/b/c/d for the next pixel and keeps
// accepted pixels in a one-line RAM. Optional macro CTX_RAM_OREG_EN registers the RAM read data.
module context_pixel_dec #(
  parameter int WIDTH  = 512,
  parameter int HEIGHT = 512,
  parameter int AW     = 9,
  parameter int RW     = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          px_valid,
  input  logic [7:0]    px_in,
  output logic [7:0]    a,
  output logic [7:0]    b,
  output logic [7:0]    c,
  output logic [7:0]    d,
  output logic          ctx_valid,
  output logic [AW-1:0] col,
  output logic [RW-1:0] row,
  output logic          END_LINE,
  output logic          frame_done
);
  localparam logic [AW-1:0] LAST_COL = AW'(WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, FETCH2, READY, UPDATE} state_t;
  state_t state;

  logic [7:0]    ram [2**AW];
  logic [7:0]    ram_q;
  logic [7:0]    rb, rc;
  logic [7:0]    nxt_a, nxt_b, nxt_c, nxt_d;
  logic [AW-1:0] rd_addr;
  logic          accept;

  always_comb begin
    rd_addr = col + AW'(1);
    accept  = (state == READY) && px_valid;
  end

  always_ff @(posedge clk) begin
    if (accept) ram[col] <= px_in;
  end

`ifdef CTX_RAM_OREG_EN
  always_ff @(posedge clk) begin
    if (state == FETCH) ram_q <= ram[rd_addr];
  end
`else
  always_comb ram_q = ram[rd_addr];
`endif

  // Edge rules: row 0 has no upper neighbours; col 0 restarts from Rb/Rc;
  // the last column reuses the new b as d since there is no NE pixel.
  always_comb begin
    nxt_a = a;
    nxt_b = d;
    nxt_c = b;
    nxt_d = ram_q;
    if (row == '0) begin
      nxt_b = '0;
      nxt_c = '0;
      nxt_d = '0;
      if (col == '0) nxt_a = '0;
    end else if (col == '0) begin
      nxt_a = rb;
      nxt_b = rb;
      nxt_c = rc;
    end else if (col == LAST_COL) begin
      nxt_d = d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      a          <= '0;
      b          <= '0;
      c          <= '0;
      d          <= '0;
      rb         <= '0;
      rc         <= '0;
      ctx_valid  <= 1'b0;
      col        <= '0;
      row        <= '0;
      END_LINE   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: if (start) state <= FETCH;
`ifdef CTX_RAM_OREG_EN
        FETCH: state <= FETCH2;
        FETCH2: begin
`else
        FETCH: begin
`endif
          state     <= READY;
          a         <= nxt_a;
          b         <= nxt_b;
          c         <= nxt_c;
          d         <= nxt_d;
          ctx_valid <= 1'b1;
          END_LINE  <= (col == LAST_COL);
        end
        // The pixel is captured on the accept edge; UPDATE only advances the counters.
        READY: if (px_valid) begin
          state     <= UPDATE;
          ctx_valid <= 1'b0;
          END_LINE  <= 1'b0;
          a         <= px_in;
          if (col == '0) begin
            rb <= px_in;
            rc <= (row == '0) ? '0 : rb;
          end
          if (col == LAST_COL && row == LAST_ROW) frame_done <= 1'b1;
        end
        UPDATE: begin
          if (col == LAST_COL) begin
            col <= '0;
            if (row == LAST_ROW) begin
              row   <= '0;
              state <= IDLE;
            end else begin
              row   <= row + RW'(1);
              state <= FETCH;
            end
          end else begin
            col   <= col + AW'(1);
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_context_pixel_dec.sv
// Directed bench for context_pixel_dec on a 4x3 frame; latency expectations follow
// the CTX_RAM_OREG_EN build setting.
module tb_context_pixel_dec;
  localparam int WIDTH  = 4;
  localparam int HEIGHT = 3;
  localparam int AW     = 2;
  localparam int RW     = 2;
`ifdef CTX_RAM_OREG_EN
  localparam int LAT_ACC   = 4;
  localparam int LAT_START = 3;
`else
  localparam int LAT_ACC   = 3;
  localparam int LAT_START = 2;
`endif

  logic          clk = 1'b0;
  logic          reset, start, px_valid;
  logic [7:0]    px_in;
  logic [7:0]    a, b, c, d;
  logic          ctx_valid, END_LINE, frame_done;
  logic [AW-1:0] col;
  logic [RW-1:0] row;

  int pass_cnt = 0;
  int total    = 0;
  logic [31:0] exp_ctx [12];
  logic [7:0]  px_tab  [12];

  always #5 clk = ~clk;

  context_pixel_dec #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .AW(AW), .RW(RW)) dut (
    .clk(clk), .reset(reset), .start(start), .px_valid(px_valid), .px_in(px_in),
    .a(a), .b(b), .c(c), .d(d), .ctx_valid(ctx_valid), .col(col), .row(row),
    .END_LINE(END_LINE), .frame_done(frame_done)
  );

  task automatic wait_ctx(output int n);
    n = 0;
    while (ctx_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic accept(input logic [7:0] v, output logic fd);
    px_in    = v;
    px_valid = 1'b1;
    @(negedge clk);
    fd       = frame_done;
    px_valid = 1'b0;
  endtask

  task automatic pulse_start(output int lat);
    int n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ctx(n);
    lat = n + 1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; px_valid = 1'b0; px_in = '0;
    repeat (2) @(negedge clk);
    total++; if ({a, b, c, d} !== 32'h0) $display("FAIL reset_ctx: got %h required 0", {a, b, c, d}); else pass_cnt++;
    total++; if ({ctx_valid, END_LINE, frame_done} !== 3'b000) $display("FAIL reset_flags: got %b required 000", {ctx_valid, END_LINE, frame_done}); else pass_cnt++;
    total++; if ({col, row} !== 4'h0) $display("FAIL reset_pos: got %h required 0", {col, row}); else pass_cnt++;
    reset = 1'b0;
    px_valid = 1'b1;
    repeat (2) @(negedge clk);
    px_valid = 1'b0;
    total++; if ({ctx_valid, col} !== 3'b000) $display("FAIL idle_px_valid: got %b required 000", {ctx_valid, col}); else pass_cnt++;
  endtask

  task automatic test_frame;
    int lat, n;
    logic fd;
    logic [AW+RW:0] exp_pos;
    pulse_start(lat);
    total++; if (lat != LAT_START) $display("FAIL start_latency: got %0d required %0d", lat, LAT_START); else pass_cnt++;
    for (int i = 0; i < 12; i++) begin
      exp_pos = {(i % WIDTH == WIDTH - 1), AW'(i % WIDTH), RW'(i / WIDTH)};
      total++; if ({a, b, c, d} !== exp_ctx[i]) $display("FAIL ctx[%0d]: got %h required %h", i, {a, b, c, d}, exp_ctx[i]); else pass_cnt++;
      total++; if ({END_LINE, col, row} !== exp_pos) $display("FAIL pos[%0d]: got %b required %b", i, {END_LINE, col, row}, exp_pos); else pass_cnt++;
      accept(px_tab[i], fd);
      if (i < 11) begin
        wait_ctx(n);
        total++; if (n + 1 != LAT_ACC) $display("FAIL accept_latency[%0d]: got %0d required %0d", i, n + 1, LAT_ACC); else pass_cnt++;
      end
    end
    total++; if (fd !== 1'b1) $display("FAIL frame_done_pulse: got %b required 1", fd); else pass_cnt++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (frame_done !== 1'b0) $display("FAIL frame_done_width: got %b required 0", frame_done); else pass_cnt++;
    n = 0;
    repeat (5) begin
      if (ctx_valid !== 1'b0 || frame_done !== 1'b0) n++;
      @(negedge clk);
    end
    total++; if (n != 0) $display("FAIL idle_after_frame: got %0d active cycles required 0", n); else pass_cnt++;
    total++; if ({col, row} !== 4'h0) $display("FAIL pos_after_frame: got %h required 0", {col, row}); else pass_cnt++;
  endtask

  task automatic test_stall;
    int lat, bad, n;
    logic [31:0] snap;
    pulse_start(lat);
    snap = {a, b, c, d};
    bad  = 0;
    repeat (5) begin
      @(negedge clk);
      if ({a, b, c, d} !== snap || ctx_valid !== 1'b1) bad++;
    end
    total++; if (bad != 0) $display("FAIL stall_stable: got %0d changes required 0", bad); else pass_cnt++;
    total++; if (snap !== exp_ctx[0]) $display("FAIL stall_ctx0: got %h required %h", snap, exp_ctx[0]); else pass_cnt++;
    px_in = px_tab[0];
    px_valid = 1'b1;
    repeat (3) @(negedge clk);
    px_valid = 1'b0;
    wait_ctx(n);
    total++; if ({ctx_valid, col, row} !== {1'b1, AW'(1), RW'(0)}) $display("FAIL px_valid_outside_ready: got %b required 10100", {ctx_valid, col, row}); else pass_cnt++;
    total++; if ({a, b, c, d} !== exp_ctx[1]) $display("FAIL stall_ctx1: got %h required %h", {a, b, c, d}, exp_ctx[1]); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int n;
    logic fd;
    for (int i = 1; i < 5; i++) begin
      accept(px_tab[i], fd);
      wait_ctx(n);
    end
    total++; if ({col, row} !== {AW'(1), RW'(1)}) $display("FAIL mid_position: got %b required 0101", {col, row}); else pass_cnt++;
    reset = 1'b1;
    #1;
    total++; if ({a, b, c, d} !== 32'h0) $display("FAIL reset_mid_ctx: got %h required 0", {a, b, c, d}); else pass_cnt++;
    total++; if ({ctx_valid, END_LINE, col, row} !== 6'h0) $display("FAIL reset_mid_state: got %b required 0", {ctx_valid, END_LINE, col, row}); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    pulse_start(n);
    for (int i = 0; i < 4; i++) begin
      total++; if ({a, b, c, d} !== exp_ctx[i]) $display("FAIL restart_ctx[%0d]: got %h required %h", i, {a, b, c, d}, exp_ctx[i]); else pass_cnt++;
      accept(px_tab[i], fd);
      wait_ctx(n);
    end
    total++; if ({a, b, c, d} !== exp_ctx[4]) $display("FAIL restart_ctx[4]: got %h required %h", {a, b, c, d}, exp_ctx[4]); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int k, last, cyc, bad_int, lat;
    logic fd_seen;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pulse_start(lat);
    px_valid = 1'b1;
    k = 0; last = -1; cyc = 0; bad_int = 0; fd_seen = 1'b0;
    while (k < 12 && cyc < 300) begin
      if (ctx_valid === 1'b1) begin
        total++; if ({a, b, c, d} !== exp_ctx[k]) $display("FAIL b2b_ctx[%0d]: got %h required %h", k, {a, b, c, d}, exp_ctx[k]); else pass_cnt++;
        if (last >= 0 && cyc - last != LAT_ACC) bad_int++;
        last  = cyc;
        px_in = px_tab[k];
        k++;
        if (k == 6) start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (frame_done === 1'b1) fd_seen = 1'b1;
    end
    px_valid = 1'b0;
    start    = 1'b0;
    total++; if (k != 12) $display("FAIL b2b_accepts: got %0d required 12", k); else pass_cnt++;
    total++; if (bad_int != 0) $display("FAIL b2b_interval: got %0d bad intervals required 0", bad_int); else pass_cnt++;
    total++; if (fd_seen !== 1'b1) $display("FAIL b2b_frame_done: got %b required 1", fd_seen); else pass_cnt++;
  endtask

  initial begin
    px_tab  = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd20, 8'd21, 8'd22, 8'd23, 8'd30, 8'd31, 8'd32, 8'd33};
    exp_ctx = '{{8'd0,  8'd0,  8'd0,  8'd0},
                {8'd10, 8'd0,  8'd0,  8'd0},
                {8'd11, 8'd0,  8'd0,  8'd0},
                {8'd12, 8'd0,  8'd0,  8'd0},
                {8'd10, 8'd10, 8'd0,  8'd11},
                {8'd20, 8'd11, 8'd10, 8'd12},
                {8'd21, 8'd12, 8'd11, 8'd13},
                {8'd22, 8'd13, 8'd12, 8'd13},
                {8'd20, 8'd20, 8'd10, 8'd21},
                {8'd30, 8'd21, 8'd20, 8'd22},
                {8'd31, 8'd22, 8'd21, 8'd23},
                {8'd32, 8'd23, 8'd22, 8'd23}};
    test_reset();
    test_frame();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
